// File: rtl/pool_frame_ctrl_if.sv
// rtl/pool_frame_ctrl_if.sv - handshake bundle between conv stream, pooling unit and frame sequencer
//
// Purpose: groups the per-frame control and status signals of the 2x2 max-pool
// frame sequencer so they travel as one port.
// Signals:
//   start       scheduler -> ctrl   one-cycle frame request
//   conv_valid  conv      -> ctrl   conv output pixel valid
//   pool_valid  pool      -> ctrl   pooled output valid
//   pool_en     ctrl      -> pool   gated pixel strobe
//   pool_rst_n  ctrl      -> pool   local active-low clear
//   busy/done   ctrl      -> sched  frame status
//   col/row     ctrl      -> any    position of the pixel being accepted
//   out_count   ctrl      -> any    pooled outputs counted this frame
//   err         ctrl      -> sched  sticky protocol error
// master: environment side (drives requests/strobes); slave: the sequencer.
interface pool_frame_ctrl_if #(
  parameter int COL_BIT = 5,
  parameter int ROW_BIT = 5,
  parameter int OUT_BIT = 8
) ();
  logic               start;
  logic               conv_valid;
  logic               pool_valid;
  logic               pool_en;
  logic               pool_rst_n;
  logic               busy;
  logic               done;
  logic [COL_BIT-1:0] col;
  logic [ROW_BIT-1:0] row;
  logic [OUT_BIT-1:0] out_count;
  logic               err;

  modport master (
    output start, conv_valid, pool_valid,
    input  pool_en, pool_rst_n, busy, done, col, row, out_count, err
  );

  modport slave (
    input  start, conv_valid, pool_valid,
    output pool_en, pool_rst_n, busy, done, col, row, out_count, err
  );
endinterface

// File: rtl/pool_frame_ctrl.sv
// rtl/pool_frame_ctrl.sv - frame sequencer for the 2x2 max-pool + ReLU stage
//
// Purpose: arms the pooling unit once per frame, gates the conv valid strobe
// into it, tracks input row/column, counts pooled outputs, pulses done when the
// last pooled output of the frame is counted and flags stream protocol errors.
// Ports:
//   clk    in  single rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    pool_frame_ctrl_if.slave (start, conv_valid, pool_valid in;
//          pool_en, pool_rst_n, busy, done, col, row, out_count, err out)
module pool_frame_ctrl #(
  parameter int WIDTH   = 24,
  parameter int HEIGHT  = 24,
  parameter int COL_BIT = 5,
  parameter int ROW_BIT = 5,
  parameter int OUT_BIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  pool_frame_ctrl_if.slave    bus
);

  localparam logic [COL_BIT-1:0] COL_LAST  = COL_BIT'(WIDTH - 1);
  localparam logic [ROW_BIT-1:0] ROW_LAST  = ROW_BIT'(HEIGHT - 1);
  localparam logic [OUT_BIT-1:0] OUT_TOTAL = OUT_BIT'((WIDTH / 2) * (HEIGHT / 2));

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [COL_BIT-1:0] r_col;
  logic [ROW_BIT-1:0] r_row;
  logic [OUT_BIT-1:0] r_out_count;
  logic               r_err;

  logic               w_accept;
  logic               w_pix;
  logic               w_col_wrap;
  logic               w_frame_end;
  logic               w_cnt_inc;
  logic [OUT_BIT-1:0] w_cnt_next;
  logic               w_err_evt;
  logic               w_busy;
  logic               w_done;
  logic               w_pool_en;
  logic               w_clear;

  assign w_accept    = (r_state == S_IDLE) && bus.start;
  assign w_pix       = (r_state == S_RUN) && bus.conv_valid;
  assign w_col_wrap  = w_pix && (r_col == COL_LAST);
  assign w_frame_end = w_col_wrap && (r_row == ROW_LAST);

  // Output counter saturates at the frame total; surplus outputs only raise err.
  assign w_cnt_inc  = ((r_state == S_RUN) || (r_state == S_DRAIN)) &&
                      bus.pool_valid && (r_out_count != OUT_TOTAL);
  assign w_cnt_next = r_out_count + {{(OUT_BIT-1){1'b0}}, w_cnt_inc};

  assign w_err_evt = (bus.conv_valid && (r_state != S_RUN)) ||
                     (bus.pool_valid && (r_out_count == OUT_TOTAL)) ||
                     (bus.pool_valid && ((r_state == S_IDLE) || (r_state == S_CLEAR)));

  always_comb begin
    w_next    = r_state;
    w_busy    = 1'b1;
    w_done    = 1'b0;
    w_pool_en = 1'b0;
    w_clear   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.start) w_next = S_CLEAR;
      end
      S_CLEAR: begin
        w_clear = 1'b1;
        w_next  = S_RUN;
      end
      S_RUN: begin
        // Strobe is combinational so the pooling unit sees it with its pixel.
        w_pool_en = bus.conv_valid;
        if (w_frame_end) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        // Uses the post-increment count so a final output arriving on the
        // DRAIN entry cycle still moves to DONE on the next edge.
        if (w_cnt_next == OUT_TOTAL) w_next = S_DONE;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_count <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_count <= '0;
      // An error event on the accepting cycle still counts for the new frame.
      r_err       <= w_err_evt;
    end else begin
      if (w_pix) begin
        if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_frame_end ? '0 : r_row + ROW_BIT'(1);
        end else begin
          r_col <= r_col + COL_BIT'(1);
        end
      end
      r_out_count <= w_cnt_next;
      if (w_err_evt) r_err <= 1'b1;
    end
  end

  assign bus.busy      = w_busy;
  assign bus.done      = w_done;
  assign bus.pool_en   = w_pool_en;
  // Held low while the global reset is asserted as well as during CLEAR.
  assign bus.pool_rst_n = rst_n && !w_clear;
  assign bus.col       = r_col;
  assign bus.row       = r_row;
  assign bus.out_count = r_out_count;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// tb/tb_pool_frame_ctrl.sv - scoreboard bench for pool_frame_ctrl
module tb_pool_frame_ctrl;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       pool_en;
    logic       pool_rst_n;
    logic       err;
    logic [4:0] col;
    logic [4:0] row;
    logic [7:0] out_count;
  } obs_t;

  typedef struct {
    int         cyc;
    logic [7:0] cnt;
    logic       e;
  } done_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pool_frame_ctrl_if #(.COL_BIT(5), .ROW_BIT(5), .OUT_BIT(8)) bus ();

  pool_frame_ctrl #(
    .WIDTH(24), .HEIGHT(24), .COL_BIT(5), .ROW_BIT(5), .OUT_BIT(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  obs_t  snap_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    end_req = 1'b0;
  bit    end_ack = 1'b0;

  logic [4:0] m_col = '0;
  logic [4:0] m_row = '0;
  logic [7:0] m_cnt = '0;
  logic       m_err = 1'b0;

  // Monitor: sole owner of the check/error counters.
  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    done_t d;
    a = '{busy: bus.busy, done: bus.done, pool_en: bus.pool_en,
          pool_rst_n: bus.pool_rst_n, err: bus.err, col: bus.col,
          row: bus.row, out_count: bus.out_count};
    if (snap_q.size() > 0) begin
      e = snap_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL snap cyc=%0d: got busy=%b done=%b pool_en=%b pool_rst_n=%b err=%b col=%0d row=%0d cnt=%0d, exp busy=%b done=%b pool_en=%b pool_rst_n=%b err=%b col=%0d row=%0d cnt=%0d",
                 cyc, a.busy, a.done, a.pool_en, a.pool_rst_n, a.err, a.col, a.row, a.out_count,
                 e.busy, e.done, e.pool_en, e.pool_rst_n, e.err, e.col, e.row, e.out_count);
      end
    end
    if (bus.done === 1'b1) begin
      checks++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d: got done=1, exp done=0", cyc);
      end else begin
        d = done_q.pop_front();
        if (cyc != d.cyc || bus.out_count !== d.cnt || bus.err !== d.e) begin
          errors++;
          $display("FAIL done_pulse: got cyc=%0d cnt=%0d err=%b, exp cyc=%0d cnt=%0d err=%b",
                   cyc, bus.out_count, bus.err, d.cyc, d.cnt, d.e);
        end
      end
    end
    if (end_req && !end_ack) begin
      checks++;
      if (done_q.size() != 0 || snap_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d done and %0d snap pending, exp 0 and 0",
                 done_q.size(), snap_q.size());
      end
      end_ack = 1'b1;
    end
  end

  function automatic obs_t mk(input logic b, input logic d, input logic pe, input logic pr);
    mk = '{busy: b, done: d, pool_en: pe, pool_rst_n: pr, err: m_err,
           col: m_col, row: m_row, out_count: m_cnt};
  endfunction

  task automatic drive(input logic s, input logic cv, input logic pv, input obs_t e);
    @(posedge clk);
    #1;
    bus.start      = s;
    bus.conv_valid = cv;
    bus.pool_valid = pv;
    snap_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.conv_valid = 1'b0;
    bus.pool_valid = 1'b0;
    m_col = '0;
    m_row = '0;
    m_cnt = '0;
    m_err = 1'b0;
    snap_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_frame(input bit gapped, input bit early, input bit mid_start,
                           input bit extra, input int abort_at);
    int   p;
    int   t;
    int   k;
    logic pend;
    logic cv;
    logic pv;
    logic s;
    logic win;
    drive(1'b1, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
    m_col = '0;
    m_row = '0;
    m_cnt = '0;
    m_err = 1'b0;
    drive(1'b0, early, 1'b0, mk(1'b1, 1'b0, 1'b0, 1'b0));
    if (early) m_err = 1'b1;
    p = 0;
    t = 0;
    k = 0;
    pend = 1'b0;
    while (p < 576) begin
      if (abort_at >= 0 && p == abort_at) begin
        do_reset();
        return;
      end
      cv = !(gapped && (t % 2 == 1));
      pv = pend;
      s  = mid_start && (p == 100) && cv;
      drive(s, cv, pv, mk(1'b1, 1'b0, cv, 1'b1));
      if (pv) m_cnt = m_cnt + 8'd1;
      win = 1'b0;
      if (cv) begin
        win = m_col[0] && m_row[0];
        k = cyc;
        p++;
        if (m_col == 5'd23) begin
          m_col = '0;
          m_row = (m_row == 5'd23) ? 5'd0 : m_row + 5'd1;
        end else begin
          m_col = m_col + 5'd1;
        end
      end
      pend = win;
      t++;
    end
    drive(1'b0, 1'b0, pend, mk(1'b1, 1'b0, 1'b0, 1'b1));
    if (pend) m_cnt = m_cnt + 8'd1;
    done_q.push_back('{k + 2, 8'd144, m_err});
    drive(1'b0, 1'b0, 1'b0, mk(1'b1, 1'b1, 1'b0, 1'b1));
    drive(1'b0, 1'b0, extra, mk(1'b0, 1'b0, 1'b0, 1'b1));
    if (extra) m_err = 1'b1;
    drive(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.conv_valid = 1'b0;
    bus.pool_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    snap_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));

    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1);  // nominal
    run_frame(1'b1, 1'b0, 1'b1, 1'b0, -1);  // gapped, start while busy
    run_frame(1'b0, 1'b1, 1'b0, 1'b0, -1);  // early pixel in CLEAR
    run_frame(1'b0, 1'b0, 1'b0, 1'b1, -1);  // extra output in IDLE
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, 300); // mid-frame reset
    drive(1'b0, 1'b0, 1'b0, mk(1'b0, 1'b0, 1'b0, 1'b1));
    run_frame(1'b0, 1'b0, 1'b0, 1'b0, -1);  // full frame after reset

    repeat (3) @(posedge clk);
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
